// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter
// Front-end controller for the cache simulator model. Arbitrates between a
// data-side requester and an instruction-fetch requester with round-robin,
// issues one command at a time to the cache lookup port, waits for the
// hit/miss response (with a timeout) and keeps statistics counters.
//
// Ports
//   clk_i, rst_ni              clock, synchronous active-low reset
//   d_valid_i/d_cmd_i/d_addr_i data requester; d_ready_o accepts it
//   i_valid_i/i_addr_i         instruction fetch (cmd 2); i_ready_o accepts it
//   c_req_valid_o, c_cmd_o,
//   c_addr_o, c_src_o          one-cycle request to the cache (src 1 = ifetch)
//   c_resp_valid_i, c_hit_i    cache response strobe and hit flag
//   clr_stats_i                synchronous clear of all statistics
//   busy_o                     controller not idle
//   cache_read_o, cache_write_o, cache_hit_o, cache_miss_o, timeout_cnt_o
//                              saturating statistics counters
module cache_req_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              d_valid_i,
    input  logic [2:0]        d_cmd_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    output logic              d_ready_o,
    input  logic              i_valid_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_ready_o,
    output logic              c_req_valid_o,
    output logic [2:0]        c_cmd_o,
    output logic [ADDR_W-1:0] c_addr_o,
    output logic              c_src_o,
    input  logic              c_resp_valid_i,
    input  logic              c_hit_i,
    input  logic              clr_stats_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  cache_read_o,
    output logic [CNT_W-1:0]  cache_write_o,
    output logic [CNT_W-1:0]  cache_hit_o,
    output logic [CNT_W-1:0]  cache_miss_o,
    output logic [CNT_W-1:0]  timeout_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t            state_q;
    logic              last_grant_q;
    logic [7:0]        wait_cnt_q;
    logic              c_req_valid_q;
    logic [2:0]        c_cmd_q;
    logic [ADDR_W-1:0] c_addr_q;
    logic              c_src_q;

    logic [CNT_W-1:0] read_q, write_q, hit_q, miss_q, to_q;
    logic [CNT_W-1:0] read_d, write_d, hit_d, miss_d, to_d;

    logic       grant_d, grant_i, accept;
    logic [2:0] acc_cmd;
    logic       in_wait, resp, counted;
    logic       inc_read, inc_write, inc_hit, inc_miss, inc_to;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Data wins unless the instruction side is also valid and data was
    // granted last; last_grant_q = 1 means instruction was granted last.
    assign grant_d   = d_valid_i && (!i_valid_i || last_grant_q);
    assign grant_i   = i_valid_i && !grant_d;
    assign d_ready_o = rst_ni && (state_q == S_IDLE) && grant_d;
    assign i_ready_o = rst_ni && (state_q == S_IDLE) && grant_i;
    assign accept    = d_ready_o || i_ready_o;
    assign acc_cmd   = grant_d ? d_cmd_i : 3'd2;

    assign in_wait   = (state_q == S_WAIT);
    assign resp      = in_wait && c_resp_valid_i;
    assign counted   = (c_cmd_q <= 3'd2);
    assign inc_read  = accept && ((acc_cmd == 3'd0) || (acc_cmd == 3'd2));
    assign inc_write = accept && (acc_cmd == 3'd1);
    assign inc_hit   = resp && counted && c_hit_i;
    assign inc_miss  = resp && counted && !c_hit_i;
    // A response on the final WAIT cycle takes priority over the timeout.
    assign inc_to    = in_wait && !c_resp_valid_i && (wait_cnt_q == LAST_WAIT);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            wait_cnt_q    <= 8'd0;
            c_req_valid_q <= 1'b0;
            c_cmd_q       <= 3'd0;
            c_addr_q      <= '0;
            c_src_q       <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    c_req_valid_q <= 1'b0;
                    if (accept) begin
                        c_cmd_q       <= acc_cmd;
                        c_addr_q      <= grant_d ? d_addr_i : i_addr_i;
                        c_src_q       <= !grant_d;
                        last_grant_q  <= !grant_d;
                        c_req_valid_q <= 1'b1;
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    c_req_valid_q <= 1'b0;
                    wait_cnt_q    <= 8'd0;
                    state_q       <= S_WAIT;
                end
                S_WAIT: begin
                    c_req_valid_q <= 1'b0;
                    if (resp || inc_to) begin
                        state_q <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: begin
                    c_req_valid_q <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    // Clear has priority over any increment on the same edge.
    always_comb begin
        read_d  = inc_read  ? sat_inc(read_q)  : read_q;
        write_d = inc_write ? sat_inc(write_q) : write_q;
        hit_d   = inc_hit   ? sat_inc(hit_q)   : hit_q;
        miss_d  = inc_miss  ? sat_inc(miss_q)  : miss_q;
        to_d    = inc_to    ? sat_inc(to_q)    : to_q;
        if (clr_stats_i) begin
            read_d  = '0;
            write_d = '0;
            hit_d   = '0;
            miss_d  = '0;
            to_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            read_q  <= '0;
            write_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            to_q    <= '0;
        end else begin
            read_q  <= read_d;
            write_q <= write_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            to_q    <= to_d;
        end
    end

    assign c_req_valid_o = c_req_valid_q;
    assign c_cmd_o       = c_cmd_q;
    assign c_addr_o      = c_addr_q;
    assign c_src_o       = c_src_q;
    assign busy_o        = (state_q != S_IDLE);
    assign cache_read_o  = read_q;
    assign cache_write_o = write_q;
    assign cache_hit_o   = hit_q;
    assign cache_miss_o  = miss_q;
    assign timeout_cnt_o = to_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed testbench for cache_req_arbiter. A second instance with a 2-bit
// counter width shares all inputs so counter saturation can be observed.
module tb_cache_req_arbiter;

    logic        clk;
    logic        rstN;
    logic        dValid;
    logic [2:0]  dCmd;
    logic [31:0] dAddr;
    logic        iValid;
    logic [31:0] iAddr;
    logic        respValid;
    logic        hit;
    logic        clrStats;

    logic        dReady, iReady, reqValid, src, busy;
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [31:0] rdCnt, wrCnt, hitCnt, missCnt, toCnt;

    logic        sDReady, sIReady, sReqValid, sSrc, sBusy;
    logic [2:0]  sCmd;
    logic [31:0] sAddr;
    logic [1:0]  sRdCnt, sWrCnt, sHitCnt, sMissCnt, sToCnt;

    int checks = 0;
    int errors = 0;
    int busyCycles;
    logic expSrc;

    cache_req_arbiter dut (
        .clk_i(clk), .rst_ni(rstN),
        .d_valid_i(dValid), .d_cmd_i(dCmd), .d_addr_i(dAddr), .d_ready_o(dReady),
        .i_valid_i(iValid), .i_addr_i(iAddr), .i_ready_o(iReady),
        .c_req_valid_o(reqValid), .c_cmd_o(cmd), .c_addr_o(addr), .c_src_o(src),
        .c_resp_valid_i(respValid), .c_hit_i(hit), .clr_stats_i(clrStats),
        .busy_o(busy),
        .cache_read_o(rdCnt), .cache_write_o(wrCnt), .cache_hit_o(hitCnt),
        .cache_miss_o(missCnt), .timeout_cnt_o(toCnt)
    );

    cache_req_arbiter #(.CNT_W(2)) dutSat (
        .clk_i(clk), .rst_ni(rstN),
        .d_valid_i(dValid), .d_cmd_i(dCmd), .d_addr_i(dAddr), .d_ready_o(sDReady),
        .i_valid_i(iValid), .i_addr_i(iAddr), .i_ready_o(sIReady),
        .c_req_valid_o(sReqValid), .c_cmd_o(sCmd), .c_addr_o(sAddr), .c_src_o(sSrc),
        .c_resp_valid_i(respValid), .c_hit_i(hit), .clr_stats_i(clrStats),
        .busy_o(sBusy),
        .cache_read_o(sRdCnt), .cache_write_o(sWrCnt), .cache_hit_o(sHitCnt),
        .cache_miss_o(sMissCnt), .timeout_cnt_o(sToCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic [2:0] dc, input logic [31:0] da,
                                 input logic iv, input logic [31:0] ia,
                                 input logic rv, input logic h, input logic clr);
        dValid    = dv;
        dCmd      = dc;
        dAddr     = da;
        iValid    = iv;
        iAddr     = ia;
        respValid = rv;
        hit       = h;
        clrStats  = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One data-side request that gets a response in its first WAIT cycle.
    task automatic serveData(input logic [2:0] c, input logic [31:0] a, input logic h);
        applyStimulus(1'b1, c, a, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("mix_d_ready", dReady, 1'b1);
        step(1);
        dValid = 1'b0;
        checkOutput("mix_req_valid", reqValid, 1'b1);
        checkOutput("mix_cmd", cmd, c);
        checkOutput("mix_addr", addr, a);
        checkOutput("mix_src", src, 1'b0);
        step(1);
        respValid = 1'b1;
        hit       = h;
        step(1);
        respValid = 1'b0;
        checkOutput("mix_idle", busy, 1'b0);
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(1'b1, 3'd0, 32'hA000_0000, 1'b1, 32'hB000_0000, 1'b0, 1'b0, 1'b0);

        // Reset held with both requesters valid
        step(2);
        checkOutput("rst_d_ready", dReady, 1'b0);
        checkOutput("rst_i_ready", iReady, 1'b0);
        checkOutput("rst_req_valid", reqValid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_cmd", cmd, 3'd0);
        checkOutput("rst_addr", addr, 32'h0);
        checkOutput("rst_src", src, 1'b0);
        checkOutput("rst_read", rdCnt, 32'd0);
        checkOutput("rst_hit", hitCnt, 32'd0);
        checkOutput("rst_timeout", toCnt, 32'd0);
        rstN = 1'b1;
        #1;
        checkOutput("rel_d_ready", dReady, 1'b1);
        checkOutput("rel_i_ready", iReady, 1'b0);

        // Round-robin with both requesters always valid, hit after one WAIT cycle
        for (int g = 0; g < 4; g++) begin
            expSrc = (g % 2 == 1);
            checkOutput("rr_d_ready", dReady, !expSrc);
            checkOutput("rr_i_ready", iReady, expSrc);
            step(1);
            checkOutput("rr_req_valid", reqValid, 1'b1);
            checkOutput("rr_src", src, expSrc);
            checkOutput("rr_cmd", cmd, expSrc ? 3'd2 : 3'd0);
            checkOutput("rr_addr", addr, expSrc ? 32'hB000_0000 : 32'hA000_0000);
            checkOutput("rr_no_ready", {dReady, iReady}, 2'b00);
            step(1);
            checkOutput("rr_req_drop", reqValid, 1'b0);
            respValid = 1'b1;
            hit       = 1'b1;
            step(1);
            respValid = 1'b0;
            checkOutput("rr_busy", busy, 1'b0);
        end
        dValid = 1'b0;
        iValid = 1'b0;
        checkOutput("rr_read", rdCnt, 32'd4);
        checkOutput("rr_hit", hitCnt, 32'd4);
        checkOutput("rr_sat_read", sRdCnt, 2'd3);

        // Mixed data stream: READ miss, WRITE hit, WRITE miss, snoop hit
        serveData(3'd0, 32'h0000_1000, 1'b0);
        serveData(3'd1, 32'h0000_2000, 1'b1);
        serveData(3'd1, 32'h0000_3000, 1'b0);
        serveData(3'd4, 32'h0000_4000, 1'b1);
        checkOutput("mix_read", rdCnt, 32'd5);
        checkOutput("mix_write", wrCnt, 32'd2);
        checkOutput("mix_hit", hitCnt, 32'd5);
        checkOutput("mix_miss", missCnt, 32'd2);
        checkOutput("mix_timeout", toCnt, 32'd0);
        checkOutput("sat_read5", sRdCnt, 2'd3);
        checkOutput("sat_hit", sHitCnt, 2'd3);
        checkOutput("sat_write", sWrCnt, 2'd2);

        // Clear while idle
        clrStats = 1'b1;
        step(1);
        clrStats = 1'b0;
        checkOutput("clr_read", rdCnt, 32'd0);
        checkOutput("clr_hit", hitCnt, 32'd0);
        checkOutput("clr_sat_read", sRdCnt, 2'd0);

        // Timeout: no response ever arrives
        applyStimulus(1'b1, 3'd0, 32'h0000_5000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1);
        dValid = 1'b0;
        busyCycles = 0;
        while (busy && busyCycles < 40) begin
            busyCycles++;
            step(1);
        end
        checkOutput("to_busy_cycles", busyCycles, 16);
        checkOutput("to_count", toCnt, 32'd1);
        checkOutput("to_hit", hitCnt, 32'd0);
        checkOutput("to_miss", missCnt, 32'd0);

        // Response in the 15th WAIT cycle beats the timeout
        dValid = 1'b1;
        step(1);
        dValid = 1'b0;
        step(15);
        checkOutput("late_busy", busy, 1'b1);
        respValid = 1'b1;
        hit       = 1'b1;
        step(1);
        respValid = 1'b0;
        checkOutput("late_hit", hitCnt, 32'd1);
        checkOutput("late_timeout", toCnt, 32'd1);
        checkOutput("late_idle", busy, 1'b0);

        // Clear on the same edge as an accepted READ
        dValid   = 1'b1;
        clrStats = 1'b1;
        step(1);
        dValid   = 1'b0;
        clrStats = 1'b0;
        checkOutput("cvi_read", rdCnt, 32'd0);
        checkOutput("cvi_timeout", toCnt, 32'd0);
        step(1);
        respValid = 1'b1;
        hit       = 1'b1;
        step(1);
        respValid = 1'b0;
        checkOutput("cvi_hit", hitCnt, 32'd1);
        checkOutput("cvi_read_after", rdCnt, 32'd0);

        // Reset while waiting for a response
        applyStimulus(1'b1, 3'd1, 32'h0000_6000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1);
        dValid = 1'b0;
        checkOutput("mid_write", wrCnt, 32'd1);
        step(2);
        checkOutput("mid_busy_before", busy, 1'b1);
        rstN = 1'b0;
        step(1);
        checkOutput("mid_busy", busy, 1'b0);
        checkOutput("mid_req_valid", reqValid, 1'b0);
        checkOutput("mid_timeout", toCnt, 32'd0);
        checkOutput("mid_write_rst", wrCnt, 32'd0);
        rstN      = 1'b1;
        respValid = 1'b1;
        hit       = 1'b1;
        step(2);
        respValid = 1'b0;
        checkOutput("stray_hit", hitCnt, 32'd0);
        checkOutput("stray_miss", missCnt, 32'd0);
        checkOutput("stray_busy", busy, 1'b0);
        step(20);
        checkOutput("stray_timeout", toCnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
